// File: rtl/traffic_conflict_monitor.sv
// rtl/traffic_conflict_monitor.sv - lamp-drive safety watchdog with sticky fault cause/direction masks
// Decodes each direction's lamps per cycle and latches conflict, multi-lamp, dark, sequence and short-yellow faults.
module traffic_conflict_monitor #(
  parameter int MIN_YELLOW = 1,
  parameter int DARK_LIMIT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ra,
  input  logic       Ga,
  input  logic       Ya,
  input  logic       Rb,
  input  logic       Gb,
  input  logic       Yb,
  input  logic       clear_fault,
  output logic       fault,
  output logic [4:0] fault_code,
  output logic [1:0] fault_dir
);

  localparam int YW = $clog2(MIN_YELLOW + 2);
  localparam int DW = $clog2(DARK_LIMIT + 2);
  localparam logic [YW-1:0] Y_SAT = YW'(MIN_YELLOW);
  localparam logic [DW-1:0] D_LIM = DW'(DARK_LIMIT);
  localparam logic [DW-1:0] D_SAT = DW'(DARK_LIMIT + 1);

  typedef enum logic [1:0] {ST_R, ST_G, ST_Y} lamp_e;

  logic [1:0][2:0] lamps;
  logic [1:0]      lit;
  logic [1:0]      dark;
  lamp_e           cur [2];

  lamp_e           last_lit_q [2];
  lamp_e           last_lit_d [2];
  logic [1:0]      lit_valid_q, lit_valid_d;
  logic [YW-1:0]   ycnt_q [2];
  logic [YW-1:0]   ycnt_d [2];
  logic [DW-1:0]   dcnt_q [2];
  logic [DW-1:0]   dcnt_d [2];
  logic            fault_q, fault_d;
  logic [4:0]      fault_code_q, fault_code_d;
  logic [1:0]      fault_dir_q, fault_dir_d;
  logic [4:0]      code_new;
  logic [1:0]      dir_new;
  logic            legal;

  // Index 0 is direction A, index 1 is direction B; each lane is {R,G,Y}.
  assign lamps = {{Rb, Gb, Yb}, {Ra, Ga, Ya}};

  always_comb begin
    code_new = '0;
    dir_new  = '0;
    legal    = 1'b1;
    for (int d = 0; d < 2; d++) begin
      lit[d]  = (lamps[d] == 3'b100) || (lamps[d] == 3'b010) || (lamps[d] == 3'b001);
      dark[d] = (lamps[d] == 3'b000);
      cur[d]  = lamps[d][2] ? ST_R : (lamps[d][1] ? ST_G : ST_Y);
    end

    if (lit[0] && lit[1] && cur[0] != ST_R && cur[1] != ST_R) begin
      code_new[0] = 1'b1;
      dir_new     = 2'b11;
    end

    for (int d = 0; d < 2; d++) begin
      last_lit_d[d]  = last_lit_q[d];
      lit_valid_d[d] = lit_valid_q[d];
      ycnt_d[d]      = ycnt_q[d];
      dcnt_d[d]      = dcnt_q[d];
      if (lit[d]) begin
        legal = (cur[d] == last_lit_q[d]) ||
                (last_lit_q[d] == ST_R && cur[d] == ST_G) ||
                (last_lit_q[d] == ST_G && cur[d] == ST_Y) ||
                (last_lit_q[d] == ST_Y && cur[d] == ST_R);
        if (lit_valid_q[d] && !legal) begin
          code_new[3] = 1'b1;
          dir_new[d]  = 1'b1;
        end
        if (lit_valid_q[d] && last_lit_q[d] == ST_Y && cur[d] == ST_R && ycnt_q[d] < Y_SAT) begin
          code_new[4] = 1'b1;
          dir_new[d]  = 1'b1;
        end
        last_lit_d[d]  = cur[d];
        lit_valid_d[d] = 1'b1;
        dcnt_d[d]      = '0;
        if (cur[d] == ST_Y)
          ycnt_d[d] = (ycnt_q[d] == Y_SAT) ? Y_SAT : ycnt_q[d] + 1'b1;
        else
          ycnt_d[d] = '0;
      end else if (dark[d]) begin
        // last_lit and ycnt hold so the sequence check spans the dark gap.
        if (dcnt_q[d] >= D_LIM) begin
          code_new[2] = 1'b1;
          dir_new[d]  = 1'b1;
        end
        dcnt_d[d] = (dcnt_q[d] == D_SAT) ? D_SAT : dcnt_q[d] + 1'b1;
      end else begin
        code_new[1]    = 1'b1;
        dir_new[d]     = 1'b1;
        lit_valid_d[d] = 1'b0;
        ycnt_d[d]      = '0;
        dcnt_d[d]      = '0;
      end
    end

    // A violation in the clear cycle wins: only the new causes survive.
    fault_code_d = (clear_fault ? 5'b0 : fault_code_q) | code_new;
    fault_dir_d  = (clear_fault ? 2'b0 : fault_dir_q) | dir_new;
    fault_d      = |fault_code_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        last_lit_q[d] <= ST_R;
        ycnt_q[d]     <= '0;
        dcnt_q[d]     <= '0;
      end
      lit_valid_q  <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= '0;
      fault_dir_q  <= '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        last_lit_q[d] <= last_lit_d[d];
        ycnt_q[d]     <= ycnt_d[d];
        dcnt_q[d]     <= dcnt_d[d];
      end
      lit_valid_q  <= lit_valid_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      fault_dir_q  <= fault_dir_d;
    end
  end

  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign fault_dir  = fault_dir_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb/tb_traffic_conflict_monitor.sv - bench for traffic_conflict_monitor
// Two instances (default and MIN_YELLOW=3/DARK_LIMIT=0) share stimulus and are compared to a phase-order model.
module tb_traffic_conflict_monitor;

  localparam logic [2:0] L_R = 3'b100, L_G = 3'b010, L_Y = 3'b001, L_OFF = 3'b000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] la = L_OFF, lb = L_OFF;
  logic       clr = 1'b0;
  logic       fault0, fault1;
  logic [4:0] code0, code1;
  logic [1:0] dir0, dir1;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  traffic_conflict_monitor u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .Ra(la[2]), .Ga(la[1]), .Ya(la[0]), .Rb(lb[2]), .Gb(lb[1]), .Yb(lb[0]),
    .clear_fault(clr), .fault(fault0), .fault_code(code0), .fault_dir(dir0)
  );

  traffic_conflict_monitor #(.MIN_YELLOW(3), .DARK_LIMIT(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .Ra(la[2]), .Ga(la[1]), .Ya(la[0]), .Rb(lb[2]), .Gb(lb[1]), .Yb(lb[0]),
    .clear_fault(clr), .fault(fault1), .fault_code(code1), .fault_dir(dir1)
  );

  // Reference model: phase index R=0,G=1,Y=2 advancing cyclically; -1 = no valid lit history.
  int         my_p [2] = '{1, 3};
  int         dl_p [2] = '{2, 0};
  int         last_m [2][2];
  int         yrun [2][2];
  int         drun [2][2];
  logic [4:0] code_m [2];
  logic [1:0] dir_m [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int phase_of(input logic [2:0] l);
    if (l[2]) return 0;
    if (l[1]) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int d = 0; d < 2; d++) begin
        last_m[i][d] = -1;
        yrun[i][d] = 0;
        drun[i][d] = 0;
      end
      code_m[i] = '0;
      dir_m[i] = '0;
    end
  endtask

  task automatic model_step(input logic [2:0] a, input logic [2:0] b, input logic c_in);
    logic [2:0] lm [2];
    int         n [2];
    int         ph [2];
    logic [4:0] c;
    logic [1:0] dm;
    lm[0] = a;
    lm[1] = b;
    for (int d = 0; d < 2; d++) begin
      n[d] = $countones(lm[d]);
      ph[d] = phase_of(lm[d]);
    end
    for (int i = 0; i < 2; i++) begin
      c = '0;
      dm = '0;
      if (n[0] == 1 && n[1] == 1 && ph[0] != 0 && ph[1] != 0) begin
        c[0] = 1'b1;
        dm = 2'b11;
      end
      for (int d = 0; d < 2; d++) begin
        if (n[d] >= 2) begin
          c[1] = 1'b1; dm[d] = 1'b1;
          last_m[i][d] = -1; yrun[i][d] = 0; drun[i][d] = 0;
        end else if (n[d] == 0) begin
          if (drun[i][d] >= dl_p[i]) begin c[2] = 1'b1; dm[d] = 1'b1; end
          drun[i][d]++;
        end else begin
          if (last_m[i][d] >= 0 && ph[d] != last_m[i][d] && ph[d] != (last_m[i][d] + 1) % 3) begin
            c[3] = 1'b1; dm[d] = 1'b1;
          end
          if (last_m[i][d] == 2 && ph[d] == 0 && yrun[i][d] < my_p[i]) begin
            c[4] = 1'b1; dm[d] = 1'b1;
          end
          yrun[i][d] = (ph[d] == 2) ? yrun[i][d] + 1 : 0;
          last_m[i][d] = ph[d];
          drun[i][d] = 0;
        end
      end
      code_m[i] = (c_in ? 5'b0 : code_m[i]) | c;
      dir_m[i] = (c_in ? 2'b0 : dir_m[i]) | dm;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".u0.fault"}, 32'(fault0), 32'(|code_m[0]));
    check({tag, ".u0.code"},  32'(code0),  32'(code_m[0]));
    check({tag, ".u0.dir"},   32'(dir0),   32'(dir_m[0]));
    check({tag, ".u1.fault"}, 32'(fault1), 32'(|code_m[1]));
    check({tag, ".u1.code"},  32'(code1),  32'(code_m[1]));
    check({tag, ".u1.dir"},   32'(dir1),   32'(dir_m[1]));
  endtask

  // Starts and ends at a falling edge.
  task automatic step(input string tag, input logic [2:0] a, input logic [2:0] b, input logic c_in);
    la = a;
    lb = b;
    clr = c_in;
    @(posedge clk);
    model_step(a, b, c_in);
    @(negedge clk);
    compare_all(tag);
    clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    la = L_OFF; lb = L_OFF; clr = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    compare_all("reset");
    do_reset();

    for (int k = 0; k < 5; k++) step("norm_ga", L_G, L_R, 1'b0);
    step("norm_ya", L_Y, L_R, 1'b0);
    for (int k = 0; k < 5; k++) step("norm_gb", L_R, L_G, 1'b0);
    step("norm_yb", L_R, L_Y, 1'b0);
    step("norm_ga2", L_G, L_R, 1'b0);
    check("normal_no_fault", 32'(fault0), 32'd0);

    do_reset();
    step("conf_pre", L_G, L_R, 1'b0);
    step("conflict", L_G, L_G, 1'b0);
    check("conflict_code", 32'(code0), 32'h01);
    check("conflict_dir", 32'(dir0), 32'h3);
    step("conf_clear", L_G, L_OFF, 1'b1);
    check("conflict_cleared", 32'({fault0, code0, dir0}), 32'd0);

    do_reset();
    for (int k = 0; k < 3; k++) step("skip_g", L_G, L_R, 1'b0);
    step("skip_r", L_R, L_R, 1'b0);
    check("skip_yellow_code", 32'(code0), 32'h08);
    check("skip_yellow_dir", 32'(dir0), 32'h1);

    do_reset();
    for (int k = 0; k < 2; k++) step("short_y", L_Y, L_R, 1'b0);
    step("short_r", L_R, L_R, 1'b0);
    check("short_yellow_code", 32'(code1), 32'h10);
    check("short_yellow_dir", 32'(dir1), 32'h1);
    check("yellow_ok_default", 32'(code0), 32'h00);

    do_reset();
    for (int k = 0; k < 2; k++) step("dark_ok", L_R, L_OFF, 1'b0);
    check("dark_limit_no_fault", 32'(fault0), 32'd0);
    step("dark3", L_R, L_OFF, 1'b0);
    check("dark_code", 32'(code0), 32'h04);
    check("dark_dir", 32'(dir0), 32'h2);
    step("multi", L_R, L_R | L_G, 1'b0);
    check("dark_multi_code", 32'(code0), 32'h06);

    do_reset();
    for (int k = 0; k < 3; k++) step("coll_dark", L_R, L_OFF, 1'b0);
    step("coll_rr", L_R, L_R, 1'b0);
    step("coll_gr", L_G, L_R, 1'b0);
    step("coll_gg", L_G, L_G, 1'b0);
    check("pre_collision_code", 32'(code0), 32'h05);
    step("coll_clr", L_G, L_G, 1'b1);
    check("collision_fault", 32'(fault0), 32'd1);
    check("collision_code", 32'(code0), 32'h01);

    do_reset();
    step("mid_g", L_G, L_R, 1'b0);
    step("mid_r", L_R, L_R, 1'b0);
    check("mid_seq_code", 32'(code0), 32'h08);
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs", 32'({fault0, code0, dir0, fault1, code1, dir1}), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step("post_rr", L_R, L_R, 1'b0);
    step("post_gr", L_G, L_R, 1'b0);
    check("post_reset_no_seq", 32'(fault0), 32'd0);

    do_reset();
    for (int k = 0; k < 600; k++) begin
      logic [2:0] rl [2];
      int         sel;
      for (int d = 0; d < 2; d++) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 7) rl[d] = 3'(1 << $urandom_range(0, 2));
        else if (sel == 7) rl[d] = L_OFF;
        else rl[d] = 3'($urandom_range(0, 7));
      end
      step("rand", rl[0], rl[1], ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
